ysyx_23060111_rf_csr: RTL

YSYX_23060111_RF_CSR -- requirements
Module: ysyx_23060111_rf_csr

---
 rtl/ysyx_23060111_rf_csr.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/ysyx_23060111_rf_csr.sv
// ---------------------------------------------------------------------------
// ysyx_23060111_rf_csr
//
// General-purpose register file with a per-register busy scoreboard, plus
// the small machine-mode CSR set needed for trap entry and return
// (mstatus, mtvec, mepc, mcause).
//
// Parameters
//   ADDR_WIDTH  GPR index width; the file holds 2**ADDR_WIDTH registers.
//   DATA_WIDTH  GPR/CSR data width (32 or 64).
//   NREAD       number of GPR read ports.
//
// Ports
//   clk, rst_n           rising-edge clock, asynchronous active-low reset
//   raddr / rdata        packed GPR read ports, combinational, with write
//                        bypass; register 0 always reads 0
//   rbusy                scoreboard busy flag seen by each read port
//   wen/waddr/wdata      GPR writeback; also clears the busy bit
//   iss_en/iss_rd        issue; marks the destination register busy
//   csr_op/csr_addr/
//   csr_wdata/csr_rdata  CSR access: none/write/set/clear, old value out
//   trap_en/trap_pc/
//   trap_cause           trap entry request
//   mret_en              trap return request
//   trap_target          mtvec with its mode bits cleared
//   mret_target          current mepc
//   mie                  mstatus.MIE
// ---------------------------------------------------------------------------
module ysyx_23060111_rf_csr #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int NREAD      = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,

    input  logic [NREAD*ADDR_WIDTH-1:0] raddr,
    output logic [NREAD*DATA_WIDTH-1:0] rdata,
    output logic [NREAD-1:0]            rbusy,

    input  logic                        wen,
    input  logic [ADDR_WIDTH-1:0]       waddr,
    input  logic [DATA_WIDTH-1:0]       wdata,

    input  logic                        iss_en,
    input  logic [ADDR_WIDTH-1:0]       iss_rd,

    input  logic [1:0]                  csr_op,
    input  logic [11:0]                 csr_addr,
    input  logic [DATA_WIDTH-1:0]       csr_wdata,
    output logic [DATA_WIDTH-1:0]       csr_rdata,

    input  logic                        trap_en,
    input  logic [DATA_WIDTH-1:0]       trap_pc,
    input  logic [DATA_WIDTH-1:0]       trap_cause,
    input  logic                        mret_en,

    output logic [DATA_WIDTH-1:0]       trap_target,
    output logic [DATA_WIDTH-1:0]       mret_target,
    output logic                        mie
);

    localparam int NREG = 2 ** ADDR_WIDTH;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;

    localparam logic [1:0] OP_NONE  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_SET   = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    // Clears the two low bits of an address (mepc alignment, mtvec mode).
    localparam logic [DATA_WIDTH-1:0] ALIGN_MASK = ~DATA_WIDTH'(3);

    // -----------------------------------------------------------------------
    // GPR storage and scoreboard
    // -----------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] rf [NREG];
    logic [NREG-1:0]       busy;
    logic [NREG-1:0]       busy_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                rf[i] <= '0;
            end
        end else if (wen && (waddr != '0)) begin
            rf[waddr] <= wdata;
        end
    end

    // Clear from writeback first, then set from issue, so that an issue to
    // the same register in the same cycle leaves it busy. Register 0 can
    // never be busy since it never waits for a result.
    always_comb begin
        busy_next = busy;
        if (wen) begin
            busy_next[waddr] = 1'b0;
        end
        if (iss_en) begin
            busy_next[iss_rd] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= '0;
        end else begin
            busy <= busy_next;
        end
    end

    // Read ports. A writeback to the addressed register is forwarded, and
    // since the value is then available the port reports it as not busy.
    for (genvar i = 0; i < NREAD; i++) begin : g_read
        logic [ADDR_WIDTH-1:0] ra;
        logic                  hit;

        assign ra  = raddr[i*ADDR_WIDTH +: ADDR_WIDTH];
        assign hit = wen && (waddr == ra);

        assign rdata[i*DATA_WIDTH +: DATA_WIDTH] = (ra == '0) ? '0 :
                                                   hit        ? wdata :
                                                                rf[ra];
        assign rbusy[i] = busy[ra] & ~hit;
    end

    // -----------------------------------------------------------------------
    // CSRs
    // -----------------------------------------------------------------------
    logic                  mstatus_mie;
    logic                  mstatus_mpie;
    logic [DATA_WIDTH-1:0] mtvec;
    logic [DATA_WIDTH-1:0] mepc;
    logic [DATA_WIDTH-1:0] mcause;

    logic [DATA_WIDTH-1:0] mstatus_val;
    logic [DATA_WIDTH-1:0] csr_old;
    logic [DATA_WIDTH-1:0] csr_new;

    // Only MIE and MPIE are real state. MPP is hardwired to machine mode,
    // so it reads 2'b11 and ignores whatever is written to it.
    always_comb begin
        mstatus_val        = '0;
        mstatus_val[12:11] = 2'b11;
        mstatus_val[7]     = mstatus_mpie;
        mstatus_val[3]     = mstatus_mie;
    end

    // Old value of the addressed CSR; unmapped addresses read 0.
    always_comb begin
        csr_old = '0;
        case (csr_addr)
            CSR_MSTATUS: csr_old = mstatus_val;
            CSR_MTVEC:   csr_old = mtvec;
            CSR_MEPC:    csr_old = mepc;
            CSR_MCAUSE:  csr_old = mcause;
            default:     csr_old = '0;
        endcase
    end

    assign csr_rdata = csr_old;

    // Read-modify-write result for the addressed CSR.
    always_comb begin
        csr_new = csr_old;
        case (csr_op)
            OP_WRITE: csr_new = csr_wdata;
            OP_SET:   csr_new = csr_old | csr_wdata;
            OP_CLEAR: csr_new = csr_old & ~csr_wdata;
            default:  csr_new = csr_old;
        endcase
    end

    // Trap entry beats trap return, which beats an explicit CSR access. A
    // losing CSR access is dropped entirely even if it targets a register
    // the trap or return would not touch, so software sees an all-or-nothing
    // outcome for the cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mstatus_mie  <= 1'b0;
            mstatus_mpie <= 1'b0;
            mtvec        <= '0;
            mepc         <= '0;
            mcause       <= '0;
        end else if (trap_en) begin
            mepc         <= trap_pc & ALIGN_MASK;
            mcause       <= trap_cause;
            mstatus_mpie <= mstatus_mie;
            mstatus_mie  <= 1'b0;
        end else if (mret_en) begin
            mstatus_mie  <= mstatus_mpie;
            mstatus_mpie <= 1'b1;
        end else if (csr_op != OP_NONE) begin
            case (csr_addr)
                CSR_MSTATUS: begin
                    mstatus_mie  <= csr_new[3];
                    mstatus_mpie <= csr_new[7];
                end
                CSR_MTVEC:  mtvec  <= csr_new;
                CSR_MEPC:   mepc   <= csr_new & ALIGN_MASK;
                CSR_MCAUSE: mcause <= csr_new;
                default: ;
            endcase
        end
    end

    // Driven straight from the registers, so a new mtvec/mepc shows up one
    // cycle after the write that produced it.
    assign trap_target = mtvec & ALIGN_MASK;
    assign mret_target = mepc;
    assign mie         = mstatus_mie;

endmodule
